// File: rtl/mc_chroma_ref_fetch4x4_if.sv
// mc_chroma_ref_fetch4x4_if
//   Signal bundle around the chroma reference fetcher: block request/status,
//   the search-window SRAM read port and the reference-row stream towards the
//   4x4 chroma interpolator.
//   master : the fetcher (drives status, SRAM read requests and rows)
//   slave  : the surrounding logic (address generator, SRAM, interpolator)
// Ports (signal names as seen by the fetcher):
//   start_i, ref_x_i, ref_y_i, frac_i     block request
//   busy_o, done_o                        block status
//   ref_rd_en_o, ref_rd_addr_o            SRAM read request
//   ref_rd_data_i                         SRAM read data (1-cycle latency)
//   frac_o, blk_start_o, refuv_valid_o,
//   refuv_p0_o..refuv_p6_o                reference-row stream
`timescale 1ns/1ps
interface mc_chroma_ref_fetch4x4_if #(
    parameter int PIXEL_WIDTH = 8,
    parameter int X_W         = 6,
    parameter int Y_W         = 6,
    parameter int ADDR_W      = 9
);
    logic                     start_i;
    logic [X_W-1:0]           ref_x_i;
    logic [Y_W-1:0]           ref_y_i;
    logic [5:0]               frac_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     ref_rd_en_o;
    logic [ADDR_W-1:0]        ref_rd_addr_o;
    logic [8*PIXEL_WIDTH-1:0] ref_rd_data_i;
    logic [5:0]               frac_o;
    logic                     blk_start_o;
    logic                     refuv_valid_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p0_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p1_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p2_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p3_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p4_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p5_o;
    logic [PIXEL_WIDTH-1:0]   refuv_p6_o;

    modport master (
        input  start_i, ref_x_i, ref_y_i, frac_i, ref_rd_data_i,
        output busy_o, done_o, ref_rd_en_o, ref_rd_addr_o, frac_o,
               blk_start_o, refuv_valid_o,
               refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o,
               refuv_p4_o, refuv_p5_o, refuv_p6_o
    );

    modport slave (
        output start_i, ref_x_i, ref_y_i, frac_i, ref_rd_data_i,
        input  busy_o, done_o, ref_rd_en_o, ref_rd_addr_o, frac_o,
               blk_start_o, refuv_valid_o,
               refuv_p0_o, refuv_p1_o, refuv_p2_o, refuv_p3_o,
               refuv_p4_o, refuv_p5_o, refuv_p6_o
    );
endinterface

// File: rtl/mc_chroma_ref_fetch4x4.sv
// mc_chroma_ref_fetch4x4
//   Fetches a 7x7 integer chroma reference patch from the search-window SRAM
//   (8 pixels per word) and streams it row by row to the 4x4 chroma
//   fractional interpolator, preceded by a one-cycle block-start pulse.
//   Rows whose 7 pixels straddle a word boundary need two reads (A, B);
//   otherwise one read per row.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   master side of mc_chroma_ref_fetch4x4_if (request, status,
//         SRAM read port, reference-row stream)
`timescale 1ns/1ps
module mc_chroma_ref_fetch4x4 #(
    parameter int PIXEL_WIDTH = 8,
    parameter int SW_W        = 64,
    parameter int SW_H        = 64,
    parameter int X_W         = 6,
    parameter int Y_W         = 6,
    parameter int ADDR_W      = 9
) (
    input  logic                     clk,
    input  logic                     rstn,
    mc_chroma_ref_fetch4x4_if.master bus
);

    localparam int WPR = SW_W / 8;  // SRAM words per search-window row

    if ((SW_W % 8 != 0) || (WPR * SW_H > (1 << ADDR_W))) begin : g_param_check
        $error("mc_chroma_ref_fetch4x4: SW_W/SW_H do not fit ADDR_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KICK  = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              off_q, off_d;        // x[2:0], pixel offset inside word A
    logic [5:0]              frac_q, frac_d;
    logic                    span_q, span_d;
    logic [2:0]              row_q, row_d;
    logic                    phase_q, phase_d;    // 0: word A, 1: word B
    logic [ADDR_W-1:0]       row_addr_q, row_addr_d;

    // Per-read tags, delayed one cycle to line up with the returning data.
    logic                    iss_a, iss_last, iss_final;
    logic                    ret_a_q, ret_last_q, ret_final_q;

    logic [8*PIXEL_WIDTH-1:0] a_q;
    logic [PIXEL_WIDTH-1:0]   pix_q [7];
    logic [PIXEL_WIDTH-1:0]   row_pix [7];
    logic                     valid_q;
    logic                     done_q;

    logic [X_W-1:0]           req_x;
    logic [Y_W-1:0]           req_y;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;

    assign req_x = bus.ref_x_i;
    assign req_y = bus.ref_y_i;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, read issue and request latching
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        frac_d     = frac_q;
        span_d     = span_q;
        row_d      = row_q;
        phase_d    = phase_q;
        row_addr_d = row_addr_q;
        rd_en      = 1'b0;
        rd_addr    = row_addr_q + ADDR_W'(phase_q);
        iss_a      = 1'b0;
        iss_last   = 1'b0;
        iss_final  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    off_d      = req_x[2:0];
                    frac_d     = bus.frac_i;
                    span_d     = (req_x[2:0] > 3'd1);
                    row_d      = '0;
                    phase_d    = 1'b0;
                    row_addr_d = ADDR_W'(req_y * WPR) + ADDR_W'(req_x >> 3);
                    state_d    = KICK;
                end
            end
            KICK: begin
                state_d = FETCH;
            end
            FETCH: begin
                rd_en = 1'b1;
                if (!span_q || phase_q) begin
                    // Last read of this row: the next row starts next cycle.
                    iss_last  = 1'b1;
                    iss_final = (row_q == 3'd6);
                    phase_d   = 1'b0;
                    if (row_q == 3'd6) begin
                        state_d = DRAIN;
                    end else begin
                        row_d      = row_q + 3'd1;
                        row_addr_d = row_addr_q + ADDR_W'(WPR);
                    end
                end else begin
                    iss_a   = 1'b1;
                    phase_d = 1'b1;
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            off_q      <= '0;
            frac_q     <= '0;
            span_q     <= 1'b0;
            row_q      <= '0;
            phase_q    <= 1'b0;
            row_addr_q <= '0;
        end else begin
            off_q      <= off_d;
            frac_q     <= frac_d;
            span_q     <= span_d;
            row_q      <= row_d;
            phase_q    <= phase_d;
            row_addr_q <= row_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Row assembly. In span mode word A was captured a cycle earlier and
    // word B is on the read bus; otherwise the whole row is in the word on
    // the read bus. Pixel 0 of a word sits in its most significant byte.
    // ------------------------------------------------------------------
    logic [8*PIXEL_WIDTH-1:0]  word_a, word_b;
    logic [16*PIXEL_WIDTH-1:0] shifted;

    always_comb begin
        word_a  = span_q ? a_q : bus.ref_rd_data_i;
        word_b  = span_q ? bus.ref_rd_data_i : '0;
        shifted = {word_a, word_b} << (off_q * PIXEL_WIDTH);
        for (int unsigned i = 0; i < 7; i++) begin
            row_pix[i] = shifted[PIXEL_WIDTH*(16-i)-1 -: PIXEL_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ret_a_q     <= 1'b0;
            ret_last_q  <= 1'b0;
            ret_final_q <= 1'b0;
            a_q         <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            for (int unsigned i = 0; i < 7; i++) begin
                pix_q[i] <= '0;
            end
        end else begin
            ret_a_q     <= iss_a;
            ret_last_q  <= iss_last;
            ret_final_q <= iss_final;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            if (ret_a_q) begin
                a_q <= bus.ref_rd_data_i;
            end
            if (ret_last_q) begin
                valid_q <= 1'b1;
                done_q  <= ret_final_q;
                for (int unsigned i = 0; i < 7; i++) begin
                    pix_q[i] <= row_pix[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.blk_start_o   = (state_q == KICK);
    assign bus.ref_rd_en_o   = rd_en;
    assign bus.ref_rd_addr_o = rd_addr;
    assign bus.frac_o        = frac_q;
    assign bus.refuv_valid_o = valid_q;
    assign bus.done_o        = done_q;
    assign bus.refuv_p0_o    = pix_q[0];
    assign bus.refuv_p1_o    = pix_q[1];
    assign bus.refuv_p2_o    = pix_q[2];
    assign bus.refuv_p3_o    = pix_q[3];
    assign bus.refuv_p4_o    = pix_q[4];
    assign bus.refuv_p5_o    = pix_q[5];
    assign bus.refuv_p6_o    = pix_q[6];

endmodule

// File: tb/tb_mc_chroma_ref_fetch4x4.sv
// tb_mc_chroma_ref_fetch4x4
//   Scoreboard bench: each launched block pushes its expected block-start
//   cycle, SRAM reads and rows; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_mc_chroma_ref_fetch4x4;
    localparam int PW     = 8;
    localparam int SW_W   = 64;
    localparam int SW_H   = 64;
    localparam int X_W    = 6;
    localparam int Y_W    = 6;
    localparam int ADDR_W = 9;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mc_chroma_ref_fetch4x4_if #(
        .PIXEL_WIDTH(PW), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) bus_if ();

    mc_chroma_ref_fetch4x4 #(
        .PIXEL_WIDTH(PW), .SW_W(SW_W), .SW_H(SW_H),
        .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_if)
    );

    // SRAM model, 1-cycle read latency
    logic [63:0] mem [512];
    always @(posedge clk) begin
        if (bus_if.ref_rd_en_o) bus_if.ref_rd_data_i <= mem[bus_if.ref_rd_addr_o];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct { int unsigned cyc; logic [ADDR_W-1:0] addr; } rd_t;
    typedef struct { int unsigned cyc; logic [55:0] pix; logic done; logic [5:0] frac; } row_t;
    rd_t         rd_q  [$];
    row_t        row_q [$];
    int unsigned blk_q [$];

    int mode = 0;
    function automatic logic [7:0] pixval(input int col, input int row);
        case (mode)
            0:       return 8'((row * (SW_W / 8)) + col / 8);
            1:       return 8'(col);
            default: return 8'(col * 7 + row * 13 + 5);
        endcase
    endfunction

    task automatic fill(input int m);
        mode = m;
        for (int w = 0; w < 512; w++)
            for (int k = 0; k < 8; k++)
                mem[w][63-8*k -: 8] = pixval((w % 8) * 8 + k, w / 8);
    endtask

    // Called just after a posedge; that cycle becomes cycle 0 of the block.
    task automatic launch(input int x, input int y, input logic [5:0] f);
        int unsigned c0;
        bit          span;
        rd_t         rd;
        row_t        rw;
        c0   = cyc;
        span = (x % 8) > 1;
        bus_if.start_i = 1'b1;
        bus_if.ref_x_i = X_W'(x);
        bus_if.ref_y_i = Y_W'(y);
        bus_if.frac_i  = f;
        blk_q.push_back(c0 + 1);
        for (int r = 0; r < 7; r++) begin
            rd.addr = ADDR_W'((y + r) * (SW_W / 8) + x / 8);
            if (span) begin
                rd.cyc = c0 + 2 + 2 * r;
                rd_q.push_back(rd);
                rd.cyc  = c0 + 3 + 2 * r;
                rd.addr = rd.addr + 1'b1;
                rd_q.push_back(rd);
                rw.cyc = c0 + 5 + 2 * r;
            end else begin
                rd.cyc = c0 + 2 + r;
                rd_q.push_back(rd);
                rw.cyc = c0 + 4 + r;
            end
            for (int c = 0; c < 7; c++) rw.pix[55-8*c -: 8] = pixval(x + c, y + r);
            rw.done = (r == 6);
            rw.frac = f;
            row_q.push_back(rw);
        end
        @(posedge clk);
        #1 bus_if.start_i = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (rd_q.size() + row_q.size() + blk_q.size()) != 0; i++)
            @(posedge clk);
        chk("drain_pending", rd_q.size() + row_q.size() + blk_q.size(), 0);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  bus_if.busy_o, 0);
        chk({tag, "_done"},  bus_if.done_o, 0);
        chk({tag, "_rd_en"}, bus_if.ref_rd_en_o, 0);
        chk({tag, "_blk"},   bus_if.blk_start_o, 0);
        chk({tag, "_valid"}, bus_if.refuv_valid_o, 0);
        chk({tag, "_frac"},  bus_if.frac_o, 0);
        chk({tag, "_pix"},   {bus_if.refuv_p0_o, bus_if.refuv_p1_o, bus_if.refuv_p2_o,
                              bus_if.refuv_p3_o, bus_if.refuv_p4_o, bus_if.refuv_p5_o,
                              bus_if.refuv_p6_o}, 0);
    endtask

    // Monitor
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (rstn) begin
            if (done_prev) chk("busy_fall", bus_if.busy_o, 0);
            done_prev <= bus_if.done_o;
            if (bus_if.blk_start_o) begin
                if (blk_q.size() == 0) chk("blk_unexpected", 1, 0);
                else begin
                    chk("blk_cycle", cyc, blk_q.pop_front());
                    chk("blk_busy", bus_if.busy_o, 1);
                end
            end
            if (bus_if.ref_rd_en_o) begin
                if (rd_q.size() == 0) chk("rd_unexpected", bus_if.ref_rd_addr_o, 0);
                else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    chk("rd_cycle", cyc, e.cyc);
                    chk("rd_addr", bus_if.ref_rd_addr_o, e.addr);
                end
            end
            if (bus_if.refuv_valid_o) begin
                if (row_q.size() == 0) chk("row_unexpected", 1, 0);
                else begin
                    row_t e;
                    e = row_q.pop_front();
                    chk("row_cycle", cyc, e.cyc);
                    chk("row_pix", {bus_if.refuv_p0_o, bus_if.refuv_p1_o, bus_if.refuv_p2_o,
                                    bus_if.refuv_p3_o, bus_if.refuv_p4_o, bus_if.refuv_p5_o,
                                    bus_if.refuv_p6_o}, e.pix);
                    chk("row_done", bus_if.done_o, e.done);
                    chk("row_frac", bus_if.frac_o, e.frac);
                end
            end else if (bus_if.done_o) begin
                chk("done_unexpected", 1, 0);
            end
        end else begin
            done_prev <= 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus_if.start_i = 1'b0;
        bus_if.ref_x_i = '0;
        bus_if.ref_y_i = '0;
        bus_if.frac_i  = '0;
        fill(0);
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk_all_zero("idle");

        // Aligned block, pixel = word index
        launch(8, 0, 6'b010_011);
        wait_drain();

        // Spanning block, pixel = column
        fill(1);
        launch(13, 5, 6'b101_110);
        wait_drain();

        // Last legal corner, x[2:0]=1 (no span)
        launch(57, 57, 6'b000_111);
        wait_drain();

        // Smallest spanning offset, x[2:0]=2
        fill(2);
        launch(50, 1, 6'b111_000);
        wait_drain();

        // start_i during a block is ignored; restart in the first IDLE cycle
        launch(16, 20, 6'b001_001);           // returns in cycle 1
        repeat (5) @(posedge clk);
        #1 bus_if.start_i = 1'b1;              // cycle 6
        bus_if.ref_x_i = X_W'(3);
        bus_if.ref_y_i = Y_W'(3);
        @(posedge clk);
        #1 bus_if.start_i = 1'b0;              // cycle 7
        repeat (4) @(posedge clk);
        #1 launch(45, 10, 6'b110_101);         // cycle 11: first IDLE after done
        wait_drain();

        // Reset in the middle of a spanning block
        launch(22, 30, 6'b011_100);
        repeat (5) @(posedge clk);
        #1 rstn = 1'b0;                        // cycle 6
        #1 chk_all_zero("abort");
        rd_q.delete();
        row_q.delete();
        blk_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk_all_zero("post_abort");
        launch(30, 40, 6'b100_010);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mc_chroma_ref_fetch4x4.md
Name: mc_chroma_ref_fetch4x4

Overview:
- Transmit side of the chroma reference-row stream consumed by the 4x4 chroma fractional interpolator.
- On a block request, reads a 7x7 integer chroma reference patch from the chroma search-window SRAM (8 pixels per word, 1-cycle read latency).
- Aligns each row to 7 contiguous pixels and emits the rows as refuv_valid_o with refuv_p0_o..refuv_p6_o, preceded by a one-cycle blk_start_o.
- Sits in rec_mc between the MC address generator and the interpolator; frac is latched and forwarded with the block.

Parameters:
PIXEL_WIDTH, 8, bits per chroma sample
SW_W, 64, search-window width in pixels (multiple of 8)
SW_H, 64, search-window height in pixels
X_W, 6, width of ref_x_i (log2 SW_W)
Y_W, 6, width of ref_y_i (log2 SW_H)
ADDR_W, 9, SRAM address width (log2(SW_W*SW_H/8))

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start_i  in  1  block request pulse; accepted only in IDLE
ref_x_i  in  X_W  patch top-left column (integer pel, already -1 adjusted)
ref_y_i  in  Y_W  patch top-left row
frac_i  in  6  {fracy,fracx} eighth-pel fraction, latched on accept
busy_o  out  1  high from accept through the last row
done_o  out  1  one-cycle pulse coincident with the 7th refuv_valid_o
ref_rd_en_o  out  1  SRAM read enable
ref_rd_addr_o  out  ADDR_W  word address = y*(SW_W/8) + (x>>3)
ref_rd_data_i  in  8*PIXEL_WIDTH  read data, valid the cycle after ref_rd_en_o; pixel k at bits [PIXEL_WIDTH*(8-k)-1 -: PIXEL_WIDTH]
frac_o  out  6  latched frac, stable while busy_o
blk_start_o  out  1  one-cycle block-start pulse to interpolator
refuv_valid_o  out  1  row valid
refuv_p0_o..refuv_p6_o  out  PIXEL_WIDTH each  row pixels, p0 = column ref_x

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0. Reset asserted mid-block aborts immediately; no further rows, no done_o.
- FSM states: IDLE, KICK, FETCH, DRAIN.
- IDLE: start_i=1 latches x, y, frac and sets span = (x[2:0] > 1), i.e. the 7 pixels cross a word boundary. busy_o rises the next cycle. Goes to KICK.
- KICK (1 cycle): blk_start_o=1, no read. Goes to FETCH.
- FETCH: 3-bit row counter r=0..6 and phase bit.
  - Row r issues word A at addr (y+r)*(SW_W/8)+(x>>3).
  - If span, the next cycle issues word B at A+1.
  - The first read of row r+1 follows immediately after the last read of row r, so there are no read bubbles.
  - After the last read of row 6, goes to DRAIN.
- Data path: A is captured the cycle after its read, B the cycle after its read. Output row = pixels x[2:0]..x[2:0]+6 of the concatenation {A,B}. The output is registered, and refuv_valid_o asserts one cycle after the row's last data returns.
- Latency (start_i accepted at cycle 0): blk_start_o at 1, first read at 2.
  - Aligned (span=0): refuv_valid_o at cycles 4..10, 1 row/cycle.
  - Span: refuv_valid_o at 5,7,...,17, with valid low in between. Outputs hold their last value while valid is low.
- DRAIN: waits until the last row is emitted. done_o pulses with the 7th valid. busy_o falls the cycle after, and the FSM returns to IDLE. A new start_i is accepted in that same IDLE cycle at the earliest.
- start_i while busy_o=1 is ignored; no queueing.
- No backpressure: the consumer must accept one row per valid.
- Precondition: x <= SW_W-7 and y <= SW_H-7. Out-of-range requests are not detected; addresses wrap modulo 2^ADDR_W.
- ref_rd_en_o is low in IDLE, KICK and DRAIN.

Test Plan:
- Reset then idle, no start_i -> all outputs 0, ref_rd_en_o never asserts.
- start_i, x=8, y=0, frac=6'b010_011, SRAM word n filled with pixel value = word index -> blk_start_o at cycle 1; reads at addr 1,9,17,...,49 on cycles 2..8; rows valid on cycles 4..10 with p0..p6 = 1,9,...,49; done_o at cycle 10; frac_o=6'b010_011.
- start_i, x=13, y=5 (span, x[2:0]=5), SRAM pixel = column index -> reads alternate addr 41/42, 49/50, ...; valid at cycles 5,7,...,17 with p0..p6 = 13..19.
- x=57, y=57 (last legal corner, x[2:0]=1, no span) -> 7 single-word rows, p6 = column 63, done_o after the 7th row.
- start_i pulsed again at cycle 6 of a block -> ignored; only 7 valids issued; a second start_i in the first IDLE cycle after done_o is accepted and blk_start_o follows one cycle later.
- rstn low at cycle 6 of a span block -> outputs 0 at once, no further valids or done_o; after release, a fresh start_i runs a complete correct block.
